// File: rtl/cfo_pkg.sv
// Shared widths, sample types and rounding/saturation constants for the CFO derotator.
// Saturating output stage is selected by the CFO_DEROT_SAT_EN macro.
package cfo_pkg;

  localparam int CFO_DW      = 12;
  localparam int CFO_FRAC    = 11;
  localparam int CFO_SAT_POS = (1 << (CFO_DW - 1)) - 1;
  localparam int CFO_SAT_NEG = -(1 << (CFO_DW - 1));
  localparam int CFO_RND     = 1 << (CFO_FRAC - 1);

  typedef logic signed [CFO_DW-1:0] sample_t;

  typedef struct packed {
    sample_t i;
    sample_t q;
  } cplx_t;

endpackage

// File: rtl/cfo_round_sat.sv
// Round half-up by FRAC, then saturate (CFO_DEROT_SAT_EN) or wrap to DW bits.
// Purely combinational; clip_o exists only in the saturating build.
module cfo_round_sat
  import cfo_pkg::*;
#(
  parameter int DW      = CFO_DW,
  parameter int FRAC    = CFO_FRAC,
  parameter int SAT_POS = CFO_SAT_POS,
  parameter int SAT_NEG = CFO_SAT_NEG,
  parameter int RND     = CFO_RND
) (
  input  logic signed [2*DW:0]  sum_i,
  output logic signed [DW-1:0]  res_o
`ifdef CFO_DEROT_SAT_EN
  ,
  output logic                  clip_o
`endif
);

  localparam int SW = 2*DW + 1;

  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] shf;

  always_comb begin
    rnd = sum_i + SW'(RND);
    shf = rnd >>> FRAC;
`ifdef CFO_DEROT_SAT_EN
    clip_o = 1'b0;
    res_o  = DW'(shf);
    if (shf > SW'(SAT_POS)) begin
      res_o  = DW'(SAT_POS);
      clip_o = 1'b1;
    end else if (shf < SW'(SAT_NEG)) begin
      res_o  = DW'(SAT_NEG);
      clip_o = 1'b1;
    end
`else
    res_o = DW'(shf);
`endif
  end

endmodule

// File: rtl/cfo_derotator.sv
// Purpose: rotate IQ samples by the conjugate NCO phasor, strobing the NCO once per accepted sample (sat_flag/clipping with CFO_DEROT_SAT_EN).
// Latency: 3 cycles accept-to-out_valid, 1 sample/clk. Backpressure: all stages stall together when out_valid && !out_ready.
module cfo_derotator
  import cfo_pkg::*;
#(
  parameter int DW   = CFO_DW,
  parameter int FRAC = CFO_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  output logic                 nco_en,
  input  logic signed [DW-1:0] ncos,
  input  logic signed [DW-1:0] nsin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q
`ifdef CFO_DEROT_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int PW = 2*DW;
  localparam int SW = 2*DW + 1;

  typedef struct packed {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
  } cplx_w_t;

  logic                 adv, accept;
  logic                 s1_vld_q, s2_vld_q, out_vld_q;
  cplx_w_t              s1_x_q, s1_n_q;    // s1_n_q carries cos in .i, sin in .q
  logic signed [PW-1:0] ii_q, qs_q, qc_q, si_q;
  logic signed [SW-1:0] yi, yq;
  logic signed [DW-1:0] out_i_d, out_q_d, out_i_q, out_q_q;

  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv && !rst;
  assign accept   = in_valid && in_ready;
  assign nco_en   = accept;

  // y = x * conj(n): yi = i*c + q*s, yq = q*c - i*s
  assign yi = SW'(ii_q) + SW'(qs_q);
  assign yq = SW'(qc_q) - SW'(si_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_i_q   <= '0;
      out_q_q   <= '0;
    end else if (adv) begin
      s1_vld_q  <= accept;
      s1_x_q    <= '{i: in_i, q: in_q};
      s1_n_q    <= '{i: ncos, q: nsin};
      s2_vld_q  <= s1_vld_q;
      ii_q      <= PW'(s1_x_q.i) * PW'(s1_n_q.i);
      qs_q      <= PW'(s1_x_q.q) * PW'(s1_n_q.q);
      qc_q      <= PW'(s1_x_q.q) * PW'(s1_n_q.i);
      si_q      <= PW'(s1_x_q.i) * PW'(s1_n_q.q);
      out_vld_q <= s2_vld_q;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
    end
  end

`ifdef CFO_DEROT_SAT_EN
  logic clip_i, clip_q, sat_q;

  cfo_round_sat #(.DW(DW), .FRAC(FRAC), .SAT_POS((1 << (DW-1)) - 1),
                  .SAT_NEG(-(1 << (DW-1))), .RND(1 << (FRAC-1)))
    u_rs_i (.sum_i(yi), .res_o(out_i_d), .clip_o(clip_i));

  cfo_round_sat #(.DW(DW), .FRAC(FRAC), .SAT_POS((1 << (DW-1)) - 1),
                  .SAT_NEG(-(1 << (DW-1))), .RND(1 << (FRAC-1)))
    u_rs_q (.sum_i(yq), .res_o(out_q_d), .clip_o(clip_q));

  // Sticky: only clips of real samples entering S3 count, bubbles are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (adv && s2_vld_q && (clip_i || clip_q)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  cfo_round_sat #(.DW(DW), .FRAC(FRAC), .SAT_POS((1 << (DW-1)) - 1),
                  .SAT_NEG(-(1 << (DW-1))), .RND(1 << (FRAC-1)))
    u_rs_i (.sum_i(yi), .res_o(out_i_d));

  cfo_round_sat #(.DW(DW), .FRAC(FRAC), .SAT_POS((1 << (DW-1)) - 1),
                  .SAT_NEG(-(1 << (DW-1))), .RND(1 << (FRAC-1)))
    u_rs_q (.sum_i(yq), .res_o(out_q_d));
`endif

  assign out_valid = out_vld_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;

endmodule
